// File: rtl/bus_pkg.sv
// Shared serial-bus definitions: default field widths and the initiator state encoding.
package bus_pkg;

   localparam int unsigned ADDR_WIDTH = 12;
   localparam int unsigned DATA_WIDTH = 8;

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_ADDR,
      S_WDATA,
      S_WAIT_ACK,
      S_RDATA,
      S_DONE
   } initiator_state_t;

   function automatic int unsigned max_width(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/bus_initiator_if.sv
// Host command/response and serial bus signals of one initiator port.
interface bus_initiator_if
   import bus_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = bus_pkg::ADDR_WIDTH,
   parameter int unsigned DATA_WIDTH = bus_pkg::DATA_WIDTH
);

   logic                  cmd_valid;
   logic                  cmd_ready;
   logic                  cmd_write;
   logic [ADDR_WIDTH-1:0] cmd_addr;
   logic [DATA_WIDTH-1:0] cmd_wdata;
   logic                  rsp_valid;
   logic [DATA_WIDTH-1:0] rsp_rdata;
   logic                  rsp_err;
   logic                  req;
   logic                  grant;
   logic                  bus_valid;
   logic                  bus_mode;
   logic                  bus_data;
   logic                  bus_ack;
   logic                  bus_rvalid;
   logic                  bus_rdata;

   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, grant, bus_ack, bus_rvalid, bus_rdata,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_err, req, bus_valid, bus_mode, bus_data
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata, grant, bus_ack, bus_rvalid, bus_rdata,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, req, bus_valid, bus_mode, bus_data
   );

endinterface

// File: rtl/bus_initiator_serial_shifter.sv
// Shared PISO/SIPO register with bit counter; last_bit flags the final position of a len-bit field.
module serial_shifter #(
   parameter int unsigned WIDTH = 12,
   parameter int unsigned CW    = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] load_data,
   input  logic             shift,
   input  logic             capture,
   input  logic             sin,
   input  logic             cnt_en,
   input  logic [CW-1:0]    len,
   output logic [WIDTH-1:0] data,
   output logic [CW-1:0]    cnt,
   output logic             last_bit
);

   logic [CW-1:0] cnt_d;

   assign cnt_d = load ? '0 : (cnt + CW'(cnt_en));

   // last_bit is registered against the count the register will hold next cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data     <= '0;
         cnt      <= '0;
         last_bit <= 1'b0;
      end else begin
         if (load)         data      <= load_data;
         else if (shift)   data      <= data >> 1;
         else if (capture) data[cnt] <= sin;
         cnt      <= cnt_d;
         last_bit <= (cnt_d == (len - CW'(1)));
      end
   end

endmodule

// File: rtl/bus_initiator.sv
// Serial bus initiator: one host command at a time, arbitrated, bit-serial address/data, single-cycle response.
module bus_initiator
   import bus_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = bus_pkg::ADDR_WIDTH,
   parameter int unsigned DATA_WIDTH = bus_pkg::DATA_WIDTH,
   parameter int unsigned TIMEOUT    = 64
) (
   input logic               clk,
   input logic               rst_n,
   bus_initiator_if.master   bif
);

   localparam int unsigned SW = max_width(ADDR_WIDTH, DATA_WIDTH);
   localparam int unsigned CW = $clog2(SW + 1);
   localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   initiator_state_t state, state_d;

   logic                  wr_q, wr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [TW-1:0]         tcnt;
   logic                  tmo;

   logic                  sh_load, sh_shift, sh_capture, sh_cnt_en, sh_last;
   logic [SW-1:0]         sh_load_data, sh_data;
   logic [CW-1:0]         sh_len, sh_cnt;

   logic                  err_d, bus_data_d;
   logic [DATA_WIDTH-1:0] rdata_d;

   logic                  cmd_ready_q, req_q, bus_valid_q, bus_mode_q, bus_data_q;
   logic                  rsp_valid_q, rsp_err_q;
   logic [DATA_WIDTH-1:0] rsp_rdata_q;

   serial_shifter #(.WIDTH(SW), .CW(CW)) u_shifter (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (sh_load),
      .load_data (sh_load_data),
      .shift     (sh_shift),
      .capture   (sh_capture),
      .sin       (bif.bus_rdata),
      .cnt_en    (sh_cnt_en),
      .len       (sh_len),
      .data      (sh_data),
      .cnt       (sh_cnt),
      .last_bit  (sh_last)
   );

   assign tmo = (TIMEOUT != 0) && (tcnt == TW'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_d;
   end

   // Next state plus the next value of every registered output; bus_data is staged one bit ahead
   always_comb begin
      state_d      = state;
      wr_d         = wr_q;
      wdata_d      = wdata_q;
      sh_load      = 1'b0;
      sh_load_data = '0;
      sh_shift     = 1'b0;
      sh_capture   = 1'b0;
      sh_cnt_en    = 1'b0;
      sh_len       = CW'(DATA_WIDTH);
      err_d        = 1'b0;
      rdata_d      = '0;
      bus_data_d   = 1'b0;

      unique case (state)
         S_IDLE: begin
            if (bif.cmd_valid) begin
               wr_d         = bif.cmd_write;
               wdata_d      = bif.cmd_wdata;
               sh_load      = 1'b1;
               sh_load_data = SW'(bif.cmd_addr);
               sh_len       = CW'(ADDR_WIDTH);
               state_d      = S_REQ;
            end
         end
         S_REQ: begin
            sh_len = CW'(ADDR_WIDTH);
            if (bif.grant) begin
               bus_data_d = sh_data[0];
               sh_shift   = 1'b1;
               state_d    = S_ADDR;
            end
         end
         S_ADDR: begin
            if (!bif.grant) begin
               err_d   = 1'b1;
               state_d = S_DONE;
            end else if (!sh_last) begin
               sh_len     = CW'(ADDR_WIDTH);
               bus_data_d = sh_data[0];
               sh_shift   = 1'b1;
               sh_cnt_en  = 1'b1;
            end else if (wr_q) begin
               bus_data_d   = wdata_q[0];
               sh_load      = 1'b1;
               sh_load_data = SW'(wdata_q >> 1);
               state_d      = S_WDATA;
            end else begin
               sh_load = 1'b1;
               state_d = S_RDATA;
            end
         end
         S_WDATA: begin
            if (!bif.grant) begin
               err_d   = 1'b1;
               state_d = S_DONE;
            end else if (!sh_last) begin
               bus_data_d = sh_data[0];
               sh_shift   = 1'b1;
               sh_cnt_en  = 1'b1;
            end else begin
               state_d = S_WAIT_ACK;
            end
         end
         S_WAIT_ACK: begin
            if (!bif.grant || (!bif.bus_ack && tmo)) begin
               err_d   = 1'b1;
               state_d = S_DONE;
            end else if (bif.bus_ack) begin
               state_d = S_DONE;
            end
         end
         S_RDATA: begin
            if (!bif.grant) begin
               err_d   = 1'b1;
               state_d = S_DONE;
            end else if (bif.bus_rvalid && sh_last) begin
               rdata_d = DATA_WIDTH'(sh_data | (SW'(bif.bus_rdata) << sh_cnt));
               state_d = S_DONE;
            end else begin
               sh_capture = bif.bus_rvalid;
               sh_cnt_en  = bif.bus_rvalid;
               if (tmo) begin
                  err_d   = 1'b1;
                  state_d = S_DONE;
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Datapath, wait-state timer and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q        <= 1'b0;
         wdata_q     <= '0;
         tcnt        <= '0;
         cmd_ready_q <= 1'b1;
         req_q       <= 1'b0;
         bus_valid_q <= 1'b0;
         bus_mode_q  <= 1'b0;
         bus_data_q  <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         wr_q        <= wr_d;
         wdata_q     <= wdata_d;
         tcnt        <= (state == S_WAIT_ACK || state == S_RDATA) ? (tcnt + TW'(1)) : '0;
         cmd_ready_q <= (state_d == S_IDLE);
         req_q       <= (state_d inside {S_REQ, S_ADDR, S_WDATA, S_WAIT_ACK, S_RDATA});
         bus_valid_q <= (state_d inside {S_ADDR, S_WDATA});
         bus_mode_q  <= wr_d && (state_d inside {S_ADDR, S_WDATA, S_WAIT_ACK, S_RDATA});
         bus_data_q  <= bus_data_d;
         rsp_valid_q <= (state_d == S_DONE);
         rsp_err_q   <= err_d;
         rsp_rdata_q <= rdata_d;
      end
   end

   assign bif.cmd_ready = cmd_ready_q;
   assign bif.req       = req_q;
   assign bif.bus_valid = bus_valid_q;
   assign bif.bus_mode  = bus_mode_q;
   assign bif.bus_data  = bus_data_q;
   assign bif.rsp_valid = rsp_valid_q;
   assign bif.rsp_err   = rsp_err_q;
   assign bif.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_bus_initiator.sv
// Self-checking bench for bus_initiator: directed scenarios plus randomized transfers against a transaction-level model.
module tb_bus_initiator;
   import bus_pkg::*;

   localparam int unsigned AW  = bus_pkg::ADDR_WIDTH;
   localparam int unsigned DW  = bus_pkg::DATA_WIDTH;
   localparam int          TMO = 64;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   bus_initiator_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bif ();

   bus_initiator #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TMO)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bif   (bif)
   );

   int tests = 0;
   int fails = 0;

   // Observations from the most recent transfer
   logic [31:0]   obs_vec;
   int            obs_n, c_grant, c_bus_first, c_bus_last, c_rv_last, c_rsp, viol;
   bit            got_rsp, aborted;
   logic          req_at1, rsp_err_o, done_req, done_bus_valid, post_ready, post_rsp;
   logic [DW-1:0] rsp_rdata_o;
   logic          rst_req, rst_bv, rst_rspv, rst_ready;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Serial bit stream the bus should carry: address LSB-first, then write data LSB-first; first n bits only
   function automatic logic [31:0] exp_bits(input logic wr, input logic [AW-1:0] a,
                                            input logic [DW-1:0] wd, input int n);
      logic [31:0] v = '0;
      for (int i = 0; i < int'(AW); i++) v[i] = a[i];
      if (wr) for (int i = 0; i < int'(DW); i++) v[int'(AW) + i] = wd[i];
      for (int i = 0; i < 32; i++) if (i >= n) v[i] = 1'b0;
      return v;
   endfunction

   // Drive one command and act as arbiter (grant follows req one cycle later) and target.
   // Cycle c=1 is the cycle right after the accepting edge.
   task automatic run_txn(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                          input logic [DW-1:0] rd, input int ack_delay, input bit ack_tied,
                          input int rv_period, input int block_cycles, input int drop_at,
                          input int rst_at);
      int   c = 0, bits = 0, wait_c = 0, rd_cyc = 0, rd_sent = 0;
      int   block = block_cycles;
      logic req_prev = 1'b0;
      bit   force_low = 1'b0;
      obs_vec = '0; obs_n = 0; c_grant = -1; c_bus_first = -1; c_bus_last = -1;
      c_rv_last = -1; c_rsp = -1; viol = 0; got_rsp = 0; aborted = 0; req_at1 = 1'b0;
      if (bif.cmd_ready !== 1'b1) viol++;
      bif.cmd_valid = 1'b1; bif.cmd_write = wr; bif.cmd_addr = a; bif.cmd_wdata = wd;
      bif.bus_ack = ack_tied;
      while (!got_rsp && c < 400) begin
         @(posedge clk); #1; c++;
         if (c == 1) req_at1 = bif.req;
         if (bif.bus_valid) begin
            if (obs_n < 32) obs_vec[obs_n] = bif.bus_data;
            obs_n++; bits++;
            if (c_bus_first < 0) c_bus_first = c;
            c_bus_last = c;
            if (bif.bus_mode !== wr) viol++;
         end else if (bif.bus_data !== 1'b0) viol++;
         if (!bif.req && bif.bus_mode !== 1'b0) viol++;
         if (c_grant < 0 && (bif.req !== 1'b1 || bif.bus_valid !== 1'b0 || bif.cmd_ready !== 1'b0)) viol++;
         if (bif.rsp_valid) begin
            got_rsp = 1; c_rsp = c; rsp_err_o = bif.rsp_err; rsp_rdata_o = bif.rsp_rdata;
            done_req = bif.req; done_bus_valid = bif.bus_valid;
         end
         if (rst_at > 0 && bits == rst_at) begin
            rst_n = 1'b0; #1;
            rst_req = bif.req; rst_bv = bif.bus_valid; rst_rspv = bif.rsp_valid; rst_ready = bif.cmd_ready;
            aborted = 1;
            break;
         end
         // commands while busy must be ignored
         bif.cmd_valid = got_rsp ? 1'b0 : 1'($urandom_range(0, 1));
         bif.cmd_write = 1'($urandom); bif.cmd_addr = AW'($urandom); bif.cmd_wdata = DW'($urandom);
         if (drop_at >= 0 && bits == drop_at + 1 && bif.bus_valid) force_low = 1;
         bif.grant = !force_low && block == 0 && req_prev;
         if (bif.grant && c_grant < 0) c_grant = c;
         if (block > 0) block--;
         req_prev = bif.req;
         bif.bus_ack = ack_tied;
         if (wr && bits == int'(AW + DW) && !bif.bus_valid && !got_rsp) begin
            if (wait_c >= ack_delay) bif.bus_ack = 1'b1;
            wait_c++;
         end
         bif.bus_rvalid = 1'b0; bif.bus_rdata = 1'($urandom);
         if (!wr && bits == int'(AW) && !bif.bus_valid && !got_rsp && rd_sent < int'(DW)) begin
            if (rd_cyc % rv_period == rv_period - 1) begin
               bif.bus_rvalid = 1'b1; bif.bus_rdata = rd[rd_sent]; rd_sent++; c_rv_last = c;
            end
            rd_cyc++;
         end
      end
      if (got_rsp) begin
         bif.cmd_valid = 1'b0; bif.grant = 1'b0; bif.bus_ack = 1'b0; bif.bus_rvalid = 1'b0;
         @(posedge clk); #1;
         post_ready = bif.cmd_ready; post_rsp = bif.rsp_valid;
      end
   endtask

   // Run a transfer and compare it with the transaction-level expectation
   task automatic txn_check(input string tag, input logic wr, input logic [AW-1:0] a,
                            input logic [DW-1:0] wd, input logic [DW-1:0] rd, input int ack_delay,
                            input bit ack_tied, input int rv_period, input int block_cycles,
                            input int drop_at);
      int nb, first, exp_rsp;
      logic err;
      run_txn(wr, a, wd, rd, ack_delay, ack_tied, rv_period, block_cycles, drop_at, 0);
      nb    = (drop_at >= 0) ? drop_at + 1 : (wr ? int'(AW + DW) : int'(AW));
      first = (block_cycles + 2 > 3) ? block_cycles + 2 : 3;
      err   = (drop_at >= 0) || (wr && !ack_tied && ack_delay >= TMO);
      if (drop_at >= 0)                     exp_rsp = c_bus_last + 1;
      else if (!wr)                         exp_rsp = c_rv_last + 1;
      else if (ack_tied)                    exp_rsp = c_bus_last + 2;
      else if (ack_delay >= TMO)            exp_rsp = c_bus_last + 1 + TMO;
      else                                  exp_rsp = c_bus_last + 2 + ack_delay;
      check({tag, ".got_rsp"},   32'(got_rsp), 32'd1);
      check({tag, ".req_c1"},    32'(req_at1), 32'd1);
      check({tag, ".first_bit"}, 32'(c_bus_first), 32'(first));
      check({tag, ".nbits"},     32'(obs_n), 32'(nb));
      check({tag, ".bits"},      obs_vec, exp_bits(wr, a, wd, nb));
      check({tag, ".rsp_cycle"}, 32'(c_rsp), 32'(exp_rsp));
      check({tag, ".rsp_err"},   32'(rsp_err_o), 32'(err));
      check({tag, ".rsp_rdata"}, 32'(rsp_rdata_o), (wr || err) ? 32'd0 : 32'(rd));
      check({tag, ".done_req"},  32'(done_req), 32'd0);
      check({tag, ".done_bv"},   32'(done_bus_valid), 32'd0);
      check({tag, ".post_ready"},32'(post_ready), 32'd1);
      check({tag, ".post_rsp"},  32'(post_rsp), 32'd0);
      check({tag, ".protocol"},  32'(viol), 32'd0);
   endtask

   initial begin
      bif.cmd_valid = 1'b0; bif.cmd_write = 1'b0; bif.cmd_addr = '0; bif.cmd_wdata = '0;
      bif.grant = 1'b0; bif.bus_ack = 1'b0; bif.bus_rvalid = 1'b0; bif.bus_rdata = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset.req",       32'(bif.req), 32'd0);
      check("reset.bus_valid", 32'(bif.bus_valid), 32'd0);
      check("reset.bus_data",  32'(bif.bus_data), 32'd0);
      check("reset.bus_mode",  32'(bif.bus_mode), 32'd0);
      check("reset.rsp_valid", 32'(bif.rsp_valid), 32'd0);
      check("reset.rsp_err",   32'(bif.rsp_err), 32'd0);
      check("reset.rsp_rdata", 32'(bif.rsp_rdata), 32'd0);
      check("reset.cmd_ready", 32'(bif.cmd_ready), 32'd1);
      rst_n = 1'b1;
      @(posedge clk); #1;

      txn_check("write_a5c", 1'b1, 12'hA5C, 8'h3C, 8'h00, 0, 1'b1, 1, 0, -1);
      check("write_a5c.rsp_at_24", 32'(c_rsp), 32'd24);
      check("write_a5c.grant_c2", 32'(c_grant), 32'd2);

      txn_check("read_5a", 1'b0, 12'h3C1, 8'h00, 8'h5A, 0, 1'b0, 2, 0, -1);
      txn_check("contention", 1'b1, 12'h123, 8'hC5, 8'h00, 1, 1'b0, 1, 10, -1);
      txn_check("timeout", 1'b1, 12'h0F0, 8'h81, 8'h00, 1000, 1'b0, 1, 0, -1);
      txn_check("grant_drop", 1'b1, 12'hFAB, 8'h77, 8'h00, 0, 1'b0, 1, 0, 5);

      // Reset in the middle of the write-data phase, then a clean transfer
      run_txn(1'b1, 12'h9E7, 8'hB2, 8'h00, 0, 1'b0, 1, 0, -1, int'(AW) + 3);
      check("rst_mid.aborted",   32'(aborted), 32'd1);
      check("rst_mid.req",       32'(rst_req), 32'd0);
      check("rst_mid.bus_valid", 32'(rst_bv), 32'd0);
      check("rst_mid.rsp_valid", 32'(rst_rspv), 32'd0);
      check("rst_mid.cmd_ready", 32'(rst_ready), 32'd1);
      bif.cmd_valid = 1'b0; bif.grant = 1'b0; bif.bus_ack = 1'b0; bif.bus_rvalid = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      txn_check("after_rst", 1'b1, 12'h4D2, 8'h6E, 8'h00, 2, 1'b0, 1, 0, -1);

      for (int i = 0; i < 12; i++) begin
         logic           wr = 1'($urandom);
         logic [AW-1:0]  a  = AW'($urandom);
         logic [DW-1:0]  wd = DW'($urandom);
         logic [DW-1:0]  rd = DW'($urandom);
         txn_check($sformatf("rand%0d", i), wr, a, wd, rd, int'($urandom_range(0, 5)), 1'b0,
                   int'($urandom_range(1, 3)), int'($urandom_range(0, 4)), -1);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
